// File: rtl/lcd_pclk_gen.sv
// Runtime-programmable LCD pixel-clock divider with valid/ready ratio updates at period boundaries.
// Optional feature macro: LCD_ID_DECODE_EN (adds lcd_id port and panel-ID ratio decode).
module lcd_pclk_gen #(
  parameter int DIV_W   = 4,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
`ifdef LCD_ID_DECODE_EN
  input  logic [15:0]      lcd_id,
`endif
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             pclk_out,
  output logic             pclk_rise_en,
  output logic             pclk_fall_en,
  output logic [DIV_W-1:0] div_cur
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cur_div;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] hi;
  logic [DIV_W-1:0] req_val;
  logic [DIV_W-1:0] reset_div;
  logic             pend;
  logic             run;
  logic             req_valid;
  logic             accept;
  logic             at_last;
  logic             apply_now;

`ifdef LCD_ID_DECODE_EN
  logic [DIV_W-1:0] dec_div;
  logic [DIV_W-1:0] req_div;
  logic             unused_ext;

  // Panel IDs are the hex codes read back from the controller.
  always_comb begin
    dec_div = '0;
    case (lcd_id)
      16'h4342: dec_div = DIV_W'(4);
      16'h7084: dec_div = DIV_W'(2);
      16'h7016: dec_div = DIV_W'(1);
      16'h4384: dec_div = DIV_W'(2);
      16'h1018: dec_div = DIV_W'(1);
      default:  dec_div = '0;
    endcase
  end

  // req_div remembers the last decoded ratio handed to the pend path, so a
  // change seen while a request is pending is retried once ready returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_div <= dec_div;
    end else if (accept) begin
      req_div <= dec_div;
    end
  end

  assign unused_ext = ^{div_val, div_valid};
  assign req_valid  = (dec_div != req_div);
  assign req_val    = dec_div;
  assign reset_div  = dec_div;
`else
  assign req_valid  = div_valid;
  assign req_val    = div_val;
  assign reset_div  = DIV_W'(DEF_DIV);
`endif

  assign hi        = {1'b0, cur_div[DIV_W-1:1]} + {{(DIV_W-1){1'b0}}, cur_div[0]};
  assign at_last   = (cur_div <= ONE) || (cnt == cur_div - ONE);
  assign accept    = req_valid && div_ready;
  assign apply_now = pend && at_last;

  // run holds everything idle for one cycle after reset so the first
  // registered rise lands on the second cycle after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_div      <= reset_div;
      cnt          <= '0;
      pend         <= 1'b0;
      pend_div     <= '0;
      div_ready    <= 1'b0;
      run          <= 1'b0;
      pclk_out     <= 1'b0;
      pclk_rise_en <= 1'b0;
      pclk_fall_en <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) begin
        pclk_out     <= (cur_div != '0) && (cnt < hi);
        pclk_rise_en <= (cur_div != '0) && (cnt == '0);
        pclk_fall_en <= (cur_div > ONE) && (cnt == hi);
      end
      if (apply_now) begin
        cur_div   <= pend_div;
        cnt       <= '0;
        pend      <= 1'b0;
        div_ready <= 1'b1;
      end else begin
        if (run) begin
          cnt <= at_last ? '0 : cnt + ONE;
        end
        if (accept) begin
          pend      <= 1'b1;
          pend_div  <= req_val;
          div_ready <= 1'b0;
        end else if (!pend) begin
          div_ready <= 1'b1;
        end
      end
    end
  end

  assign div_cur = cur_div;

endmodule

// File: tb/tb_lcd_pclk_gen.sv
// Self-checking bench for lcd_pclk_gen: cycle-by-cycle vector table plus an R=15 period sequence.
module tb_lcd_pclk_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] div_val = '0;
  logic       div_valid = 1'b0;
  logic       div_ready;
  logic       pclk_out;
  logic       pclk_rise_en;
  logic       pclk_fall_en;
  logic [3:0] div_cur;

  typedef struct {
    logic       rst_in;
    logic       valid_in;
    logic [3:0] val_in;
    logic       out;
    logic       rise;
    logic       fall;
    logic       ready;
    logic [3:0] cur;
  } vec_t;

  typedef struct {
    logic       out;
    logic       rise;
    logic       fall;
    logic       ready;
    logic [3:0] cur;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  lcd_pclk_gen #(.DIV_W(4), .DEF_DIV(2)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef LCD_ID_DECODE_EN
    .lcd_id       (16'h7084),
`endif
    .div_val      (div_val),
    .div_valid    (div_valid),
    .div_ready    (div_ready),
    .pclk_out     (pclk_out),
    .pclk_rise_en (pclk_rise_en),
    .pclk_fall_en (pclk_fall_en),
    .div_cur      (div_cur)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic add(input logic r, input logic v, input int val,
                     input logic o, input logic ri, input logic f,
                     input logic rd, input int cur);
    vec_t t;
    t.rst_in   = r;
    t.valid_in = v;
    t.val_in   = 4'(val);
    t.out      = o;
    t.rise     = ri;
    t.fall     = f;
    t.ready    = rd;
    t.cur      = 4'(cur);
    vecs.push_back(t);
  endtask

  task automatic compare(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      compare({tag, " pclk_out"},     int'(pclk_out),     int'(e.out));
      compare({tag, " pclk_rise_en"}, int'(pclk_rise_en), int'(e.rise));
      compare({tag, " pclk_fall_en"}, int'(pclk_fall_en), int'(e.fall));
      compare({tag, " div_ready"},    int'(div_ready),    int'(e.ready));
      compare({tag, " div_cur"},      int'(div_cur),      int'(e.cur));
    end
  endtask

  // Outputs are sampled first, then the inputs for this cycle are driven.
  task automatic apply_stimulus(input vec_t v, input string tag);
    exp_t e;
    e.out   = v.out;
    e.rise  = v.rise;
    e.fall  = v.fall;
    e.ready = v.ready;
    e.cur   = v.cur;
    sb.push_back(e);
    check_output(tag);
    rst       = v.rst_in;
    div_valid = v.valid_in;
    div_val   = v.val_in;
  endtask

  initial begin
    int waited;
    exp_t e;

    //   rst valid val | out rise fall ready cur
    add(0, 0,  0,  0, 0, 0, 0,  2);  // c0  reset values, release
    add(0, 0,  0,  0, 0, 0, 1,  2);
    add(0, 0,  0,  1, 1, 0, 1,  2);  // c2  first rise
    add(0, 0,  0,  0, 0, 1, 1,  2);
    add(0, 0,  0,  1, 1, 0, 1,  2);
    add(0, 1,  3,  0, 0, 1, 1,  2);  // c5  request R=3
    add(0, 0,  0,  1, 1, 0, 0,  2);
    add(0, 0,  0,  0, 0, 1, 1,  3);
    add(0, 0,  0,  1, 1, 0, 1,  3);
    add(0, 0,  0,  1, 0, 0, 1,  3);
    add(0, 0,  0,  0, 0, 1, 1,  3);
    add(0, 0,  0,  1, 1, 0, 1,  3);
    add(0, 0,  0,  1, 0, 0, 1,  3);
    add(0, 1,  4,  0, 0, 1, 1,  3);  // c13 request R=4
    add(0, 0,  0,  1, 1, 0, 0,  3);
    add(0, 0,  0,  1, 0, 0, 0,  3);
    add(0, 0,  0,  0, 0, 1, 1,  4);
    add(0, 1,  5,  1, 1, 0, 1,  4);  // c17 request R=5 at phase 1
    add(0, 0,  0,  1, 0, 0, 0,  4);
    add(0, 0,  0,  0, 0, 1, 0,  4);
    add(0, 0,  0,  0, 0, 0, 1,  5);
    add(0, 0,  0,  1, 1, 0, 1,  5);
    add(0, 0,  0,  1, 0, 0, 1,  5);
    add(0, 0,  0,  1, 0, 0, 1,  5);
    add(0, 0,  0,  0, 0, 1, 1,  5);
    add(0, 0,  0,  0, 0, 0, 1,  5);
    add(0, 1,  0,  1, 1, 0, 1,  5);  // c26 request stop
    add(0, 0,  0,  1, 0, 0, 0,  5);
    add(0, 0,  0,  1, 0, 0, 0,  5);
    add(0, 0,  0,  0, 0, 1, 0,  5);
    add(0, 0,  0,  0, 0, 0, 1,  0);
    add(0, 0,  0,  0, 0, 0, 1,  0);
    add(0, 1,  1,  0, 0, 0, 1,  0);  // c32 request R=1
    add(0, 0,  0,  0, 0, 0, 0,  0);
    add(0, 0,  0,  0, 0, 0, 1,  1);
    add(0, 0,  0,  1, 1, 0, 1,  1);
    add(0, 0,  0,  1, 1, 0, 1,  1);
    add(0, 1,  3,  1, 1, 0, 1,  1);  // c37 request R=3
    add(0, 1,  7,  1, 1, 0, 0,  1);  // c38 changed value while not ready
    add(0, 0,  0,  1, 1, 0, 1,  3);
    add(0, 0,  0,  1, 1, 0, 1,  3);
    add(0, 0,  0,  1, 0, 0, 1,  3);
    add(0, 0,  0,  0, 0, 1, 1,  3);
    add(0, 1,  5,  1, 1, 0, 1,  3);  // c43 request R=5
    add(1, 0,  0,  1, 0, 0, 0,  3);  // c44 reset while pending
    add(0, 0,  0,  0, 0, 0, 0,  2);
    add(0, 0,  0,  0, 0, 0, 1,  2);
    add(0, 0,  0,  1, 1, 0, 1,  2);
    add(0, 0,  0,  0, 0, 1, 1,  2);
    add(0, 0,  0,  1, 1, 0, 1,  2);
    add(0, 1,  2,  0, 0, 1, 1,  2);  // c50 same-ratio update
    add(0, 0,  0,  1, 1, 0, 0,  2);
    add(0, 0,  0,  0, 0, 1, 1,  2);
    add(0, 0,  0,  1, 1, 0, 1,  2);
    add(0, 1, 15,  0, 0, 1, 1,  2);  // c54 request max ratio
    add(0, 0,  0,  1, 1, 0, 0,  2);
    add(0, 0,  0,  0, 0, 1, 1, 15);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i], $sformatf("c%0d", i));
      @(negedge clk);
    end

    // R=15: high for 8 of 15 cycles, fall on phase 8, rise again after 15.
    waited = 0;
    while (!pclk_rise_en && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    compare("r15 rise_wait", int'(pclk_rise_en), 1);
    for (int k = 0; k < 16; k++) begin
      e.out   = ((k % 15) < 8);
      e.rise  = ((k % 15) == 0);
      e.fall  = ((k % 15) == 8);
      e.ready = 1'b1;
      e.cur   = 4'd15;
      sb.push_back(e);
      check_output($sformatf("r15 k%0d", k));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
